// File: rtl/mem_port_arbiter_if.sv
// Signal bundle for mem_port_arbiter: fetch/data requesters, shared memory port and status.
// slave is the arbiter's own view; master is the view of the surrounding core and memory.
interface mem_port_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic            f_req;
   logic [AW-1:0]   f_addr;
   logic            f_gnt;
   logic            f_valid;
   logic            d_req;
   logic            d_we;
   logic [AW-1:0]   d_addr;
   logic [DW-1:0]   d_wdata;
   logic [DW/8-1:0] d_be;
   logic            d_gnt;
   logic            d_valid;
   logic [DW-1:0]   rdata;
   logic            resp_err;
   logic            m_req;
   logic            m_we;
   logic [AW-1:0]   m_addr;
   logic [DW-1:0]   m_wdata;
   logic [DW/8-1:0] m_be;
   logic            m_ack;
   logic            m_rvalid;
   logic [DW-1:0]   m_rdata;
   logic            busy;

   modport slave (
      input  f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be,
      input  m_ack, m_rvalid, m_rdata,
      output f_gnt, f_valid, d_gnt, d_valid, rdata, resp_err,
      output m_req, m_we, m_addr, m_wdata, m_be, busy
   );

   modport master (
      output f_req, f_addr, d_req, d_we, d_addr, d_wdata, d_be,
      output m_ack, m_rvalid, m_rdata,
      input  f_gnt, f_valid, d_gnt, d_valid, rdata, resp_err,
      input  m_req, m_we, m_addr, m_wdata, m_be, busy
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one req/ack memory port between fetch (F) and load/store (D) with a response watchdog.
// Define ARB_ROUND_ROBIN_EN to alternate contested grants; otherwise D always wins.
module mem_port_arbiter #(
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               rst,
   mem_port_arbiter_if.slave bus
);

   localparam int CW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0]   CNT_MAX   = '1;
   localparam logic [CW-1:0]   CNT_LIMIT = CW'(TIMEOUT);
   localparam logic [DW/8-1:0] BE_ALL    = '1;

   typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
   typedef enum logic {OWN_F, OWN_D} owner_t;

   state_t        state;
   owner_t        owner;
   logic [CW-1:0] cnt;
   logic [CW-1:0] cnt_next;
   logic          timed_out;
   logic          can_grant;
   logic          pick_d;
   logic [AW-1:0] grant_addr;

`ifdef ARB_ROUND_ROBIN_EN
   owner_t last_owner;
   assign pick_d = bus.d_req && (!bus.f_req || last_owner == OWN_F);
`else
   assign pick_d = bus.d_req;
`endif

   // No grant while a response pulse is out, so a transaction never ends and starts in one cycle.
   assign can_grant  = !rst && state == IDLE && !bus.f_valid && !bus.d_valid;
   assign bus.d_gnt  = can_grant && pick_d;
   assign bus.f_gnt  = can_grant && bus.f_req && !pick_d;
   assign bus.busy   = state != IDLE;
   assign grant_addr = pick_d ? bus.d_addr : bus.f_addr;

   assign cnt_next  = (cnt == CNT_MAX) ? cnt : cnt + CW'(1);
   assign timed_out = (TIMEOUT != 0) && (cnt_next == CNT_LIMIT);

   // Transaction FSM; the memory-side fields and response pulses are all registered here.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         owner        <= OWN_F;
         cnt          <= '0;
         bus.m_req    <= 1'b0;
         bus.m_we     <= 1'b0;
         bus.m_addr   <= '0;
         bus.m_wdata  <= '0;
         bus.m_be     <= '0;
         bus.f_valid  <= 1'b0;
         bus.d_valid  <= 1'b0;
         bus.rdata    <= '0;
         bus.resp_err <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
         last_owner   <= OWN_F;
`endif
      end else begin
         bus.f_valid  <= 1'b0;
         bus.d_valid  <= 1'b0;
         bus.rdata    <= '0;
         bus.resp_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (bus.d_gnt || bus.f_gnt) begin
                  state       <= REQ;
                  owner       <= pick_d ? OWN_D : OWN_F;
                  bus.m_req   <= 1'b1;
                  bus.m_addr  <= grant_addr;
                  bus.m_we    <= pick_d && bus.d_we;
                  bus.m_wdata <= pick_d ? bus.d_wdata : '0;
                  bus.m_be    <= pick_d ? bus.d_be : BE_ALL;
`ifdef ARB_ROUND_ROBIN_EN
                  last_owner  <= pick_d ? OWN_D : OWN_F;
`endif
               end
            end
            REQ: begin
               if (bus.m_ack) begin
                  state     <= WAIT;
                  bus.m_req <= 1'b0;
                  cnt       <= '0;
               end
            end
            WAIT: begin
               cnt <= cnt_next;
               // A real response beats a watchdog expiry landing in the same cycle.
               if (bus.m_rvalid || timed_out) begin
                  state        <= IDLE;
                  bus.f_valid  <= owner == OWN_F;
                  bus.d_valid  <= owner == OWN_D;
                  bus.resp_err <= !bus.m_rvalid;
                  bus.rdata    <= (bus.m_rvalid && !bus.m_we) ? bus.m_rdata : '0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed vectors with literal expectations plus a
// transaction-level model compared against the DUT on every falling edge.
module tb_mem_port_arbiter;

   localparam int AW      = 32;
   localparam int DW      = 32;
   localparam int TIMEOUT = 4;
`ifdef ARB_ROUND_ROBIN_EN
   localparam bit RR_BUILD = 1'b1;
`else
   localparam bit RR_BUILD = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   failures = 0;

   mem_port_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_port_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, actual, expected, $time);
      end
   endtask

   // Drives one cycle of inputs just after the rising edge, then returns at the falling edge.
   task automatic applyStimulus(input int r, input int fr, input logic [31:0] fa,
                                input int dr, input int dw, input logic [31:0] da,
                                input logic [31:0] dd, input int db,
                                input int ack, input int rv, input logic [31:0] rd);
      @(posedge clk);
      #1;
      rst          = (r != 0);
      bus.f_req    = (fr != 0);
      bus.f_addr   = fa;
      bus.d_req    = (dr != 0);
      bus.d_we     = (dw != 0);
      bus.d_addr   = da;
      bus.d_wdata  = dd;
      bus.d_be     = 4'(db);
      bus.m_ack    = (ack != 0);
      bus.m_rvalid = (rv != 0);
      bus.m_rdata  = rd;
      @(negedge clk);
   endtask

   task automatic mem_cycle(input int ack, input int rv, input logic [31:0] rd);
      applyStimulus(0, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, ack, rv, rd);
   endtask

   // Transaction-level reference: one outstanding transaction, a pending response, last winner.
   bit          active, acked, cur_is_d, cur_we, last_is_d;
   bit          resp_valid, resp_is_d, resp_err_exp;
   bit          want, d_wins;
   int          waited;
   logic [31:0] cur_addr, cur_wdata, resp_data;
   logic [3:0]  cur_be;

   initial begin
      active = 0; acked = 0; last_is_d = 0; resp_valid = 0; waited = 0;
      @(posedge clk);
      forever begin
         @(negedge clk);
         want   = !rst && !active && !resp_valid;
         d_wins = bus.d_req && (!bus.f_req || !RR_BUILD || !last_is_d);
         checkOutput("model_d_gnt", 32'(bus.d_gnt), 32'(want && d_wins));
         checkOutput("model_f_gnt", 32'(bus.f_gnt), 32'(want && bus.f_req && !d_wins));
         checkOutput("model_busy", 32'(bus.busy), 32'(active));
         checkOutput("model_m_req", 32'(bus.m_req), 32'(active && !acked));
         checkOutput("model_f_valid", 32'(bus.f_valid), 32'(resp_valid && !resp_is_d));
         checkOutput("model_d_valid", 32'(bus.d_valid), 32'(resp_valid && resp_is_d));
         if (resp_valid) begin
            checkOutput("model_rdata", bus.rdata, resp_data);
            checkOutput("model_resp_err", 32'(bus.resp_err), 32'(resp_err_exp));
         end
         if (active) begin
            checkOutput("model_m_addr", bus.m_addr, cur_addr);
            checkOutput("model_m_we", 32'(bus.m_we), 32'(cur_we));
            checkOutput("model_m_wdata", bus.m_wdata, cur_wdata);
            checkOutput("model_m_be", 32'(bus.m_be), 32'(cur_be));
         end
         resp_valid = 0;
         if (rst) begin
            active    = 0;
            last_is_d = 0;
         end else if (active && !acked) begin
            if (bus.m_ack) begin
               acked  = 1;
               waited = 0;
            end
         end else if (active) begin
            waited++;
            if (bus.m_rvalid) begin
               resp_valid = 1; resp_is_d = cur_is_d; resp_err_exp = 0;
               resp_data = cur_we ? 32'h0 : bus.m_rdata;
               active = 0;
            end else if (TIMEOUT != 0 && waited == TIMEOUT) begin
               resp_valid = 1; resp_is_d = cur_is_d; resp_err_exp = 1;
               resp_data = 32'h0;
               active = 0;
            end
         end else if (want && (bus.f_req || bus.d_req)) begin
            active    = 1;
            acked     = 0;
            cur_is_d  = d_wins;
            last_is_d = d_wins;
            cur_addr  = d_wins ? bus.d_addr : bus.f_addr;
            cur_we    = d_wins && bus.d_we;
            cur_wdata = d_wins ? bus.d_wdata : 32'h0;
            cur_be    = d_wins ? bus.d_be : 4'hF;
         end
      end
   end

   initial begin
      bus.f_req = 0; bus.f_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
      bus.d_wdata = '0; bus.d_be = '0; bus.m_ack = 0; bus.m_rvalid = 0; bus.m_rdata = '0;

      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      checkOutput("reset_busy", 32'(bus.busy), 32'd0);
      checkOutput("reset_m_req", 32'(bus.m_req), 32'd0);
      checkOutput("reset_m_addr", bus.m_addr, 32'h0);
      checkOutput("reset_m_be", 32'(bus.m_be), 32'h0);
      checkOutput("reset_valids", 32'({bus.f_valid, bus.d_valid}), 32'd0);
      checkOutput("reset_rdata", bus.rdata, 32'h0);

      $display("[TB] fetch read");
      applyStimulus(0, 1, 32'h100, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      checkOutput("fetch_f_gnt", 32'(bus.f_gnt), 32'd1);
      checkOutput("fetch_d_gnt", 32'(bus.d_gnt), 32'd0);
      mem_cycle(1, 0, 32'h0);
      checkOutput("fetch_m_req", 32'(bus.m_req), 32'd1);
      checkOutput("fetch_m_addr", bus.m_addr, 32'h100);
      checkOutput("fetch_m_we", 32'(bus.m_we), 32'd0);
      checkOutput("fetch_m_be", 32'(bus.m_be), 32'hF);
      mem_cycle(0, 1, 32'h00A00093);
      checkOutput("fetch_wait_m_req", 32'(bus.m_req), 32'd0);
      checkOutput("fetch_wait_f_valid", 32'(bus.f_valid), 32'd0);
      mem_cycle(0, 0, 32'h0);
      checkOutput("fetch_f_valid", 32'(bus.f_valid), 32'd1);
      checkOutput("fetch_rdata", bus.rdata, 32'h00A00093);
      checkOutput("fetch_resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("fetch_busy_done", 32'(bus.busy), 32'd0);

      $display("[TB] contention");
      applyStimulus(0, 1, 32'h400, 1, 0, 32'h800, 32'h0, 15, 0, 0, 32'h0);
      checkOutput("cont1_d_gnt", 32'(bus.d_gnt), 32'd1);
      checkOutput("cont1_f_gnt", 32'(bus.f_gnt), 32'd0);
      applyStimulus(0, 1, 32'h400, 1, 0, 32'h800, 32'h0, 15, 1, 0, 32'h0);
      checkOutput("cont_busy_gnts", 32'({bus.f_gnt, bus.d_gnt}), 32'd0);
      checkOutput("cont1_m_addr", bus.m_addr, 32'h800);
      applyStimulus(0, 1, 32'h400, 1, 0, 32'h800, 32'h0, 15, 0, 1, 32'h11111111);
      checkOutput("cont_wait_gnts", 32'({bus.f_gnt, bus.d_gnt}), 32'd0);
      applyStimulus(0, 1, 32'h400, 1, 0, 32'h800, 32'h0, 15, 0, 0, 32'h0);
      checkOutput("cont1_d_valid", 32'(bus.d_valid), 32'd1);
      checkOutput("cont_valid_gnts", 32'({bus.f_gnt, bus.d_gnt}), 32'd0);
      applyStimulus(0, 1, 32'h400, 1, 0, 32'h800, 32'h0, 15, 0, 0, 32'h0);
      checkOutput("cont2_f_gnt", 32'(bus.f_gnt), 32'(RR_BUILD));
      checkOutput("cont2_d_gnt", 32'(bus.d_gnt), 32'(!RR_BUILD));
      mem_cycle(1, 0, 32'h0);
      checkOutput("cont2_m_addr", bus.m_addr, RR_BUILD ? 32'h400 : 32'h800);
      mem_cycle(0, 1, 32'h22222222);
      mem_cycle(0, 0, 32'h0);
      checkOutput("cont2_f_valid", 32'(bus.f_valid), 32'(RR_BUILD));
      checkOutput("cont2_rdata", bus.rdata, 32'h22222222);

      $display("[TB] store");
      applyStimulus(0, 0, 32'h0, 1, 1, 32'h2004, 32'hCAFEF00D, 3, 0, 0, 32'h0);
      checkOutput("store_d_gnt", 32'(bus.d_gnt), 32'd1);
      mem_cycle(1, 0, 32'h0);
      checkOutput("store_m_we", 32'(bus.m_we), 32'd1);
      checkOutput("store_m_addr", bus.m_addr, 32'h2004);
      checkOutput("store_m_wdata", bus.m_wdata, 32'hCAFEF00D);
      checkOutput("store_m_be", 32'(bus.m_be), 32'h3);
      mem_cycle(0, 1, 32'h12345678);
      mem_cycle(0, 0, 32'h0);
      checkOutput("store_d_valid", 32'(bus.d_valid), 32'd1);
      checkOutput("store_rdata", bus.rdata, 32'h0);
      checkOutput("store_f_valid", 32'(bus.f_valid), 32'd0);

      $display("[TB] ack stall");
      applyStimulus(0, 1, 32'h300, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         mem_cycle(0, int'(i == 2), 32'hBAD0BAD0);
         checkOutput("stall_m_req", 32'(bus.m_req), 32'd1);
         checkOutput("stall_m_addr", bus.m_addr, 32'h300);
         checkOutput("stall_busy", 32'(bus.busy), 32'd1);
         checkOutput("stall_f_valid", 32'(bus.f_valid), 32'd0);
      end
      mem_cycle(1, 0, 32'h0);
      mem_cycle(0, 1, 32'h33333333);
      mem_cycle(0, 0, 32'h0);
      checkOutput("stall_done_f_valid", 32'(bus.f_valid), 32'd1);
      checkOutput("stall_done_rdata", bus.rdata, 32'h33333333);

      $display("[TB] timeout");
      applyStimulus(0, 0, 32'h0, 1, 0, 32'h40, 32'h0, 15, 0, 0, 32'h0);
      mem_cycle(1, 0, 32'h0);
      for (int i = 0; i < 4; i++) begin
         mem_cycle(0, 0, 32'h55555555);
         checkOutput("timeout_wait_busy", 32'(bus.busy), 32'd1);
         checkOutput("timeout_wait_d_valid", 32'(bus.d_valid), 32'd0);
      end
      mem_cycle(0, 0, 32'h0);
      checkOutput("timeout_d_valid", 32'(bus.d_valid), 32'd1);
      checkOutput("timeout_resp_err", 32'(bus.resp_err), 32'd1);
      checkOutput("timeout_rdata", bus.rdata, 32'h0);
      mem_cycle(0, 1, 32'h66666666);
      mem_cycle(0, 0, 32'h0);
      checkOutput("late_rvalid_dropped", 32'({bus.f_valid, bus.d_valid}), 32'd0);

      applyStimulus(0, 0, 32'h0, 1, 0, 32'h44, 32'h0, 15, 0, 0, 32'h0);
      mem_cycle(1, 0, 32'h0);
      for (int i = 0; i < 3; i++) mem_cycle(0, 0, 32'h0);
      mem_cycle(0, 1, 32'hDEADBEEF);
      mem_cycle(0, 0, 32'h0);
      checkOutput("race_d_valid", 32'(bus.d_valid), 32'd1);
      checkOutput("race_resp_err", 32'(bus.resp_err), 32'd0);
      checkOutput("race_rdata", bus.rdata, 32'hDEADBEEF);

      $display("[TB] reset mid-transaction");
      applyStimulus(0, 1, 32'h500, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      mem_cycle(1, 0, 32'h0);
      applyStimulus(1, 0, 32'h0, 0, 0, 32'h0, 32'h0, 0, 0, 1, 32'h77777777);
      mem_cycle(0, 0, 32'h0);
      checkOutput("abort_busy", 32'(bus.busy), 32'd0);
      checkOutput("abort_m_req", 32'(bus.m_req), 32'd0);
      checkOutput("abort_valids", 32'({bus.f_valid, bus.d_valid}), 32'd0);
      mem_cycle(0, 0, 32'h0);
      checkOutput("abort_no_late_valid", 32'({bus.f_valid, bus.d_valid}), 32'd0);
      applyStimulus(0, 1, 32'h600, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0);
      checkOutput("post_reset_f_gnt", 32'(bus.f_gnt), 32'd1);
      mem_cycle(1, 0, 32'h0);
      mem_cycle(0, 1, 32'h88888888);
      mem_cycle(0, 0, 32'h0);
      checkOutput("post_reset_f_valid", 32'(bus.f_valid), 32'd1);
      checkOutput("post_reset_rdata", bus.rdata, 32'h88888888);

      mem_cycle(0, 0, 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
